// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with synchronous read ports and a pending-write scoreboard
module regfile_sb #(
    parameter int RFW = 5,
    parameter int DW  = 32,
    parameter int PCW = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [RFW-1:0] i_rs1,
    input  logic [RFW-1:0] i_rs2,
    input  logic           i_rd_en,
    output logic [DW-1:0]  o_rs1_data,
    output logic [DW-1:0]  o_rs2_data,
    output logic           o_stall,
    input  logic           i_issue_valid,
    input  logic [RFW-1:0] i_issue_rd,
    output logic           o_issue_ready,
    input  logic           i_rf_we,
    input  logic [RFW-1:0] i_wb_rd,
    input  logic [DW-1:0]  i_wb_data
);
    localparam int DEPTH = 1 << RFW;
    localparam logic [PCW-1:0] PMAX = '1;

    logic [DW-1:0]    r_mem  [DEPTH];
    logic [PCW-1:0]   r_pend [DEPTH];
    logic [DW-1:0]    r_rs1_data;
    logic [DW-1:0]    r_rs2_data;

    logic             w_retire;
    logic             w_issue;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic [DW-1:0]    w_rs1_val;
    logic [DW-1:0]    w_rs2_val;
    logic [DEPTH-1:0] w_inc;
    logic [DEPTH-1:0] w_dec;

    assign w_retire = i_rf_we && (i_wb_rd != '0);

    // A full counter can still accept an issue when the same register retires this cycle.
    assign o_issue_ready = !((r_pend[i_issue_rd] == PMAX) &&
                             !(w_retire && (i_wb_rd == i_issue_rd)));
    assign w_issue = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

    // The last outstanding write retiring now is forwarded, so it no longer blocks decode.
    assign w_rs1_busy = (i_rs1 != '0) && (r_pend[i_rs1] != '0) &&
                        !(w_retire && (i_wb_rd == i_rs1) && (r_pend[i_rs1] == PCW'(1)));
    assign w_rs2_busy = (i_rs2 != '0) && (r_pend[i_rs2] != '0) &&
                        !(w_retire && (i_wb_rd == i_rs2) && (r_pend[i_rs2] == PCW'(1)));
    assign o_stall = w_rs1_busy || w_rs2_busy;

    assign w_rs1_val = (i_rs1 == '0) ? '0 :
                       (w_retire && (i_wb_rd == i_rs1)) ? i_wb_data : r_mem[i_rs1];
    assign w_rs2_val = (i_rs2 == '0) ? '0 :
                       (w_retire && (i_wb_rd == i_rs2)) ? i_wb_data : r_mem[i_rs2];

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 1; r < DEPTH; r++) begin
            w_inc[r] = w_issue && (i_issue_rd == RFW'(r));
            w_dec[r] = w_retire && (i_wb_rd == RFW'(r));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r]  <= '0;
                r_pend[r] <= '0;
            end
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            if (w_retire) begin
                r_mem[i_wb_rd] <= i_wb_data;
            end
            for (int r = 1; r < DEPTH; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_pend[r] <= r_pend[r] + PCW'(1);
                end else if (w_dec[r] && !w_inc[r] && (r_pend[r] != '0)) begin
                    r_pend[r] <= r_pend[r] - PCW'(1);
                end
            end
            if (i_rd_en) begin
                r_rs1_data <= w_rs1_val;
                r_rs2_data <= w_rs2_val;
            end
        end
    end

    assign o_rs1_data = r_rs1_data;
    assign o_rs2_data = r_rs2_data;
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and random checks of regfile_sb against an array/counter model
module tb_regfile_sb;
    localparam int RFW  = 5;
    localparam int DW   = 32;
    localparam int PCW  = 2;
    localparam int NR   = 1 << RFW;
    localparam int PMAX = (1 << PCW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [RFW-1:0] rs1, rs2, issue_rd, wb_rd;
    logic           rd_en, issue_valid, rf_we;
    logic [DW-1:0]  wb_data;
    logic [DW-1:0]  rs1_data, rs2_data;
    logic           stall, issue_ready;

    always #5 clk = ~clk;

    regfile_sb #(.RFW(RFW), .DW(DW), .PCW(PCW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd_en(rd_en),
        .o_rs1_data(rs1_data), .o_rs2_data(rs2_data), .o_stall(stall),
        .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
        .i_rf_we(rf_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data)
    );

    logic [DW-1:0] m_mem [NR];
    int            m_pend [NR];
    logic [DW-1:0] m_d1, m_d2;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_retire();
        return rf_we && (wb_rd != 0);
    endfunction

    function automatic bit m_busy(input logic [RFW-1:0] r);
        if (r == 0 || m_pend[r] == 0) return 1'b0;
        if (m_retire() && wb_rd == r && m_pend[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        return !(m_pend[issue_rd] == PMAX && !(m_retire() && wb_rd == issue_rd));
    endfunction

    task automatic idle();
        rst = 1'b0; rs1 = '0; rs2 = '0; rd_en = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; rf_we = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check read data after the edge.
    task automatic cycle(input string tag);
        bit ret, iss;
        #1;
        if (!rst) begin
            check({tag, "/stall"}, DW'(stall), DW'(m_busy(rs1) || m_busy(rs2)));
            check({tag, "/ready"}, DW'(issue_ready), DW'(m_ready()));
        end
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[r] = '0;
                m_pend[r] = 0;
            end
            m_d1 = '0;
            m_d2 = '0;
        end else begin
            ret = m_retire();
            iss = issue_valid && m_ready() && (issue_rd != 0);
            if (rd_en) begin
                m_d1 = (rs1 == 0) ? '0 : (ret && wb_rd == rs1) ? wb_data : m_mem[rs1];
                m_d2 = (rs2 == 0) ? '0 : (ret && wb_rd == rs2) ? wb_data : m_mem[rs2];
            end
            if (ret) m_mem[wb_rd] = wb_data;
            if (!(iss && ret && issue_rd == wb_rd)) begin
                if (iss) m_pend[issue_rd] = m_pend[issue_rd] + 1;
                if (ret && m_pend[wb_rd] > 0) m_pend[wb_rd] = m_pend[wb_rd] - 1;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "/rs1_data"}, rs1_data, m_d1);
        check({tag, "/rs2_data"}, rs2_data, m_d2);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle("reset0");
        cycle("reset1");

        idle(); rf_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        cycle("x0_write");
        idle(); rs1 = 5'd0; rs2 = 5'd5; rd_en = 1'b1;
        cycle("x0_read");
        check("x0_const", rs1_data, 32'h0);
        check("x0_ready", DW'(issue_ready), 32'h1);

        idle(); rf_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234; rs1 = 5'd7; rd_en = 1'b1;
        cycle("bypass");
        check("bypass_const", rs1_data, 32'h1234);
        idle(); rs1 = 5'd7; rd_en = 1'b1;
        cycle("bypass_reread");

        idle(); issue_valid = 1'b1; issue_rd = 5'd3;
        cycle("issue3");
        idle(); rs2 = 5'd3;
        #1 check("stall3_const", DW'(stall), 32'h1);
        cycle("stall3_n1");
        idle(); rs2 = 5'd3;
        cycle("stall3_n2");
        idle(); rs2 = 5'd3; rd_en = 1'b1; rf_we = 1'b1; wb_rd = 5'd3; wb_data = $urandom;
        cycle("retire3");

        for (int k = 0; k < 3; k++) begin
            idle(); issue_valid = 1'b1; issue_rd = 5'd9;
            cycle("sat_fill");
        end
        idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        #1 check("sat_full_const", DW'(issue_ready), 32'h0);
        cycle("sat_full");
        idle(); issue_valid = 1'b1; issue_rd = 5'd9; rf_we = 1'b1; wb_rd = 5'd9; wb_data = $urandom;
        cycle("sat_retire");
        idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        cycle("sat_still_full");
        for (int k = 0; k < 3; k++) begin
            idle(); rf_we = 1'b1; wb_rd = 5'd9; wb_data = $urandom; rs1 = 5'd9;
            cycle("sat_drain");
        end

        idle(); issue_valid = 1'b1; issue_rd = 5'd6;
        cycle("issue6");
        idle(); issue_valid = 1'b1; issue_rd = 5'd4; rf_we = 1'b1; wb_rd = 5'd6; wb_data = $urandom;
        cycle("iss4_ret6");
        idle(); rs1 = 5'd4;
        cycle("pend4");
        idle(); rs1 = 5'd6;
        cycle("pend6_clear");
        idle(); rf_we = 1'b1; wb_rd = 5'd4; wb_data = $urandom;
        cycle("retire4");

        for (int k = 0; k < 2; k++) begin
            idle(); issue_valid = 1'b1; issue_rd = 5'd2;
            cycle("issue2");
        end
        idle(); rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd2; rd_en = 1'b1; rs1 = 5'd2;
        cycle("mid_reset");
        idle(); rs1 = 5'd2;
        #1 check("post_reset_stall_const", DW'(stall), 32'h0);
        cycle("post_reset");
        idle(); rf_we = 1'b1; wb_rd = 5'd2; wb_data = $urandom;
        cycle("stray_retire");
        idle(); rs1 = 5'd2; issue_rd = 5'd2;
        cycle("no_wrap");

        for (int k = 0; k < 400; k++) begin
            idle();
            rst         = ($urandom_range(0, 59) == 0);
            rs1         = RFW'($urandom_range(0, 7));
            rs2         = RFW'($urandom_range(0, 7));
            rd_en       = 1'($urandom);
            issue_valid = 1'($urandom);
            issue_rd    = RFW'($urandom_range(0, 7));
            rf_we       = ($urandom_range(0, 2) == 0);
            wb_rd       = RFW'($urandom_range(0, 7));
            wb_data     = $urandom;
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Architectural register file with a pending-write scoreboard; the write-side consumer of the writeback stage's `rf_we`/`rd` outputs. Decode reads two source operands through synchronous read ports, and marks destinations pending at issue. Writeback retires those destinations and updates the array. A combinational `stall` tells decode when a source is still in flight.

## Interface
- `RFW`, default 5: register index width; depth is 2^RFW.
- `DW`, default 32: data width.
- `PCW`, default 2: width of the per-register pending counter; max in-flight writes per register is 2^PCW−1.

- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rs1`  in  RFW  source index, read port 1.
- `rs2`  in  RFW  source index, read port 2.
- `rd_en`  in  1  capture read data this cycle.
- `rs1_data`  out  DW  registered read data, port 1.
- `rs2_data`  out  DW  registered read data, port 2.
- `stall`  out  1  a source of the current `rs1`/`rs2` is pending.
- `issue_valid`  in  1  decode issues an instruction that writes `issue_rd`.
- `issue_rd`  in  RFW  destination being issued.
- `issue_ready`  out  1  issue accepted this cycle.
- `rf_we`  in  1  writeback enable. Already 0 when rd==0.
- `wb_rd`  in  RFW  writeback destination.
- `wb_data`  in  DW  writeback data.

## Operation
- **Array:** 2^RFW × DW.
  - Entry 0 reads 0 always and is never written.
  - `rf_we` with `wb_rd`==0 is ignored.
- **Write:** on a rising edge with `rf_we`=1 and `wb_rd`≠0, `mem[wb_rd]` ← `wb_data`.
- **Read:** on a rising edge with `rd_en`=1:
  - `rsN_data` ← `mem[rsN]`, with write-first bypass: if `rf_we` && `wb_rd`==`rsN` && `rsN`≠0, capture `wb_data`.
  - If `rsN`==0, capture 0.
  - With `rd_en`=0, `rsN_data` holds.
- **Scoreboard:** `pend[r]`, PCW-bit unsigned counter per register. `pend[0]` is always 0.
  - Issue fires when `issue_valid` && `issue_ready` && `issue_rd`≠0.
  - Retire fires when `rf_we` && `wb_rd`≠0.
  - Issue only to reg r: `pend[r]`+1. Retire only to r: `pend[r]`−1. Both to the same r in one cycle: unchanged. Issue and retire to different registers update independently.
  - Retire with `pend[r]`==0 is a protocol error. The counter must stay at 0 and must not wrap.
- **issue_ready** (combinational):
  - 0 when `pend[issue_rd]`==2^PCW−1 and there is no same-cycle retire of `issue_rd`.
  - 1 otherwise, including when `issue_rd`==0.
  - An issue to x0 is accepted with no counter change.
- **stall** (combinational): 1 when `(rs1≠0 && pend[rs1]≠0) || (rs2≠0 && pend[rs2]≠0)`.
  - A register is treated as not pending if a retire to it occurs this cycle and `pend`==1. The bypass then supplies the value.
  - `stall` does not depend on `issue_valid`.

## Timing
- **Reset** (next edge with `rst`=1):
  - All `mem` entries become 0, all `pend` become 0, `rs1_data`/`rs2_data` become 0.
  - `stall`=0 and `issue_ready`=1 afterward.
  - Reset overrides a simultaneous write, issue, or read.
- **Read latency:** 1 cycle. Address presented in cycle N; data valid after edge N.
- **Write-to-read:** a write at edge N is visible to a read captured at the same edge N, through the bypass.
- **Scoreboard latency:**
  - An issue at edge N makes `stall` visible from cycle N+1.
  - A retire at edge N clears it combinationally during cycle N when `pend` was 1.
- **Reset mid-operation:** all in-flight pending state is discarded. Writebacks arriving after reset are protocol errors and follow the no-wrap rule.
- No combinational path from `wb_data` to any output. Paths from `rf_we`/`wb_rd` to `stall` and `issue_ready` are allowed.

## Test plan
- **Reset/x0:** after reset, write x0=0xDEADBEEF, then read rs1=0 and rs2=5 → both data 0, `stall`=0, `issue_ready`=1.
- **Bypass:** `rf_we`=1, `wb_rd`=7, `wb_data`=0x1234, with `rs1`=7 and `rd_en`=1 on the same edge → `rs1_data`=0x1234. Next read of x7 → 0x1234.
- **Stall/retire:**
  - Issue rd=3 at edge N. In cycle N+1, rs2=3 → `stall`=1.
  - Retire rd=3 in cycle N+3 → `stall`=0 in that cycle, and `rs2_data` captures `wb_data` at that edge.
- **Saturation:**
  - Issue rd=9 three times → `pend`=3, then `issue_ready`=0 for rd=9.
  - Same cycle as a retire of x9 → `issue_ready`=1, and `pend` stays at 3.
- **Simultaneous issue and retire, different registers:** issue rd=4 while retiring rd=6 (`pend[6]`=1) → `pend[4]`=1, `pend[6]`=0.
- **Reset mid-flight:** `pend[2]`=2, then `rst` → `pend` all 0, `stall`=0. A stray retire to x2 afterward → `pend[2]` stays 0.
